meme_uart_tx: RTL and testbench
===============================

# meme_uart_tx

Buffered 8-bit UART transmitter for the `tt_um_supreme_meme` top level. Upstream logic pushes result bytes through a valid/ready port into a small FIFO. The block serialises them LSB-first as 8N1 frames (optional even parity) on one output pin, routed to a `uio_out` bit with its `uio_oe` bit held high. It lets the chip report results to a host without the core stalling per bit.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 4: byte FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single design clock
- `rst_n`  in  1  reset; synchronous, active-low
- `ena`  in  1  tile enable; gates the start of new frames only
- `in_data`  in  8  byte to transmit
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  FIFO can accept a byte
- `tx`  out  1  serial line; idles high
- `busy`  out  1  a frame is in progress or the FIFO is non-empty
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries

## Operation
- **Push:** a byte is written on any edge where `in_valid & in_ready`. `in_ready = !full & rst_n`. `in_valid` while not ready has no effect; the producer holds the data.
- **FSM states:** IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
- **IDLE:** `tx=1`. If the FIFO is non-empty and `ena=1`, pop the head into the shift register, clear the baud counter, and go to START.
- **START:** `tx=0` for CLKS_PER_BIT cycles, then DATA.
- **DATA:** 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts them; after bit 7, go to PARITY (if enabled) or STOP.
- **STOP:** `tx=1` for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty and `ena=1`, pop and go straight to START, with no idle gap. Otherwise go to IDLE.
- **Baud counter:** $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- **`ena` low:** the current frame completes normally and pushes are still accepted. No new frame starts until `ena` returns high.
- **Push and pop together:** both happen on the same edge and `fifo_count` is unchanged. A full FIFO refuses the push even if a pop occurs that edge (`in_ready` comes from registered `full`).
- **FIFO pointers:** wrap modulo FIFO_DEPTH; full/empty are distinguished by `fifo_count`.
- **Reset mid-frame:** the frame is aborted, `tx` returns high on the next edge, and FIFO contents are discarded.

## Timing
- **Reset values:** `tx=1`, `busy=0`, `fifo_count=0`, FSM=IDLE. `in_ready=0` while `rst_n=0`, and 1 on the first cycle after release.
- **Latency:** a byte pushed at edge N into an empty FIFO with the FSM idle is popped at edge N+1. `tx` is low from edge N+1.
- **Frame length:** 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- **Register timing:** all outputs are registered except `in_ready`.
- **`busy`:** high from the edge after the first push until the edge ending the last STOP bit with the FIFO empty.

## Configuration
- **`MEME_UART_PARITY_EN` defined:** the PARITY state is compiled in. It sends even parity (XOR of the 8 data bits) for one bit time between DATA and STOP; frame is 11 bits.
- **Not defined:** no PARITY state and no parity logic; frame is 10 bits (8N1).

## Structure
- **Shared package `meme_pkg`:**
  - FSM state enum `uart_state_t` (IDLE, START, DATA, PARITY, STOP; PARITY always enumerated)
  - `UART_DATA_BITS = 8`
  - default `CLKS_PER_BIT`
- **Sub-module `meme_byte_fifo`:**
  - parameterised by `FIFO_DEPTH`
  - ports: push, pop, din, dout, full, empty, count
  - synchronous `rst_n`
  - `dout` shows the head combinationally

## Test plan
All scenarios run with CLKS_PER_BIT=4.
- **Reset:** assert `rst_n=0` for 3 cycles with `in_valid=1` → `tx=1`, `busy=0`, `fifo_count=0`, `in_ready=0`. After release, `in_ready=1` on the next cycle.
- **Single byte 0xA5:** push → `tx` low from the next edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4. `busy` drops after 40 cycles; with parity on, a 0 bit before stop and 44 cycles.
- **Back-to-back 0x00, 0xFF, 0x55:** pushed on consecutive cycles → three contiguous frames with no idle cycle between stop and start. `fifo_count` sequence is 1, 2, 2, then decrements once per frame.
- **Overflow (FIFO_DEPTH=4):** hold `in_valid` with 6 distinct bytes → exactly 5 accepted (1 popped + 4 buffered). `in_ready` is low while full, and the transmitted order matches push order.
- **`ena` gating:** push 0x3C with `ena=0` → `tx` stays high and `fifo_count=1`. Raise `ena` → start bit on the next edge. Dropping `ena` mid-frame still completes the frame.
- **Reset mid-frame:** assert `rst_n=0` during DATA bit 3 with 2 bytes queued → `tx=1` on the next edge and `fifo_count=0`. No further frames after release.

Source files
------------

// File: rtl/meme_pkg.sv
// rtl/meme_pkg.sv - shared types and constants for the meme UART transmitter
package meme_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/meme_byte_fifo.sv
// rtl/meme_byte_fifo.sv - byte FIFO with combinational head and occupancy count
module meme_byte_fifo
  import meme_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [UART_DATA_BITS-1:0]   din,
  output logic [UART_DATA_BITS-1:0]   dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [UART_DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      do_push, do_pop;

  // Pointers wrap naturally because the depth is a power of two.
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/meme_uart_tx.sv
// rtl/meme_uart_tx.sv - buffered LSB-first 8N1 UART transmitter
// Define MEME_UART_PARITY_EN to insert an even-parity bit between data and stop.
module meme_uart_tx
  import meme_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [UART_DATA_BITS-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_t               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      push, pop, start_frame, cnt_done;
`ifdef MEME_UART_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  assign in_ready    = ~fifo_full & rst_n;
  assign push        = in_valid & in_ready;
  assign start_frame = ~fifo_empty & ena;
  assign cnt_done    = (cnt_q == CNT_LAST);

  meme_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (in_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_done ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef MEME_UART_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pop   = start_frame;
      end
      START: begin
        if (cnt_done) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (cnt_done) begin
          if (bit_idx_q == BIT_LAST) begin
`ifdef MEME_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef MEME_UART_PARITY_EN
      PARITY: begin
        if (cnt_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (cnt_done) begin
          state_d = IDLE;
          pop     = start_frame;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop always launches a new frame, whether from IDLE or straight out of STOP.
    if (pop) begin
      shift_d = fifo_dout;
      cnt_d   = '0;
      state_d = START;
`ifdef MEME_UART_PARITY_EN
      parity_d = even_parity(fifo_dout);
`endif
    end
  end

  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef MEME_UART_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) | ~fifo_empty | push;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef MEME_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef MEME_UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_meme_uart_tx.sv
// tb/tb_meme_uart_tx.sv - self-checking bench for meme_uart_tx with CLKS_PER_BIT=4
module tb_meme_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef MEME_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy;
  logic [2:0] fifo_count;

  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         frames_seen = 0;
  logic [7:0] exp_q[$];
  int         frame_starts[$];

  typedef struct {
    logic [7:0] d;
    logic       par;
  } vec_t;

  meme_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got event-missing expected event", name);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) fail_now("idle_timeout");
  endtask

  // Pushes one byte; returns the cycle index of the push edge.
  task automatic push_one(input logic [7:0] d, output int n);
    in_valid = 1'b1;
    in_data  = d;
    check("push_ready", in_ready, 1);
    if (in_ready) exp_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
    n = cyc;
  endtask

  // Three pushes on consecutive edges into an idle transmitter.
  task automatic push_burst(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            output int n);
    in_valid = 1'b1;
    in_data  = a;
    check("burst_ready0", in_ready, 1);
    exp_q.push_back(a);
    @(negedge clk);
    n = cyc;
    in_data = b;
    check("burst_ready1", in_ready, 1);
    exp_q.push_back(b);
    @(negedge clk);
    check("burst_count_n1", fifo_count, 1);
    in_data = c;
    check("burst_ready2", in_ready, 1);
    exp_q.push_back(c);
    @(negedge clk);
    check("burst_count_n2", fifo_count, 2);
    in_valid = 1'b0;
    @(negedge clk);
    check("burst_count_n3", fifo_count, 2);
  endtask

  // Line monitor: decodes frames mid-bit and scores them against the expected queue.
  initial begin : monitor
    int         phase;
    logic [FB-1:0] bits;
    logic [7:0] e;
    phase = -1;
    bits  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        phase = -1;
      end else begin
        if (phase < 0) begin
          if (tx == 1'b0) begin
            phase = 0;
            frame_starts.push_back(cyc);
          end
        end else begin
          phase++;
        end
        if (phase >= 0) begin
          if (phase % CPB == 1) bits[phase/CPB] = tx;
          if (phase == FRAME - 1) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
              fail_now("mon_unexpected_frame");
            end else begin
              e = exp_q.pop_front();
              check("mon_data", bits[8:1], e);
              check("mon_framing", {bits[FB-1], bits[0]}, 2'b10);
`ifdef MEME_UART_PARITY_EN
              check("mon_parity", bits[9], ^e);
`endif
            end
            phase = -1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t          vecs[5];
    logic [7:0]    ovf[6];
    logic [FB-1:0] fr;
    int            n, idx, accepted, bad, fs0, nf;
    logic          took;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'h80, 1'b1};
    vecs[3] = '{8'h7E, 1'b0};
    vecs[4] = '{8'h13, 1'b1};
    ovf[0] = 8'h11; ovf[1] = 8'h22; ovf[2] = 8'h33;
    ovf[3] = 8'h44; ovf[4] = 8'h55; ovf[5] = 8'h66;

    // Reset with in_valid held high.
    rst_n    = 1'b0;
    ena      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_in_ready", in_ready, 0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_count", fifo_count, 0);
    check("rel_tx", tx, 1);

    // Table of single-byte frames, checked cycle by cycle.
    for (int i = 0; i < 5; i++) begin
      fr       = '1;
      fr[0]    = 1'b0;
      fr[8:1]  = vecs[i].d;
`ifdef MEME_UART_PARITY_EN
      fr[9]    = vecs[i].par;
`endif
      push_one(vecs[i].d, n);
      check($sformatf("vec%0d_tx_at_push", i), tx, 1);
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        check($sformatf("vec%0d_tx_c%0d", i, c), tx, fr[c/CPB]);
        if (c == 0 || c == FRAME - 1) check($sformatf("vec%0d_busy_c%0d", i, c), busy, 1);
      end
      @(negedge clk);
      check($sformatf("vec%0d_busy_end", i), busy, 0);
      check($sformatf("vec%0d_tx_end", i), tx, 1);
      check($sformatf("vec%0d_count_end", i), fifo_count, 0);
    end

    // Back-to-back frames with no idle gap.
    fs0 = frame_starts.size();
    push_burst(8'h00, 8'hFF, 8'h55, n);
    wait_until(n + FRAME);
    check("b2b_count_before_pop2", fifo_count, 2);
    @(negedge clk);
    check("b2b_count_after_pop2", fifo_count, 1);
    wait_until(n + 1 + 2 * FRAME);
    check("b2b_count_after_pop3", fifo_count, 0);
    wait_idle(4 * FRAME);
    check("b2b_frames", frame_starts.size() - fs0, 3);
    if (frame_starts.size() == fs0 + 3) begin
      check("b2b_first_start", frame_starts[fs0], n + 1);
      check("b2b_gap1", frame_starts[fs0+1] - frame_starts[fs0], FRAME);
      check("b2b_gap2", frame_starts[fs0+2] - frame_starts[fs0+1], FRAME);
    end

    // Overflow: hold in_valid with six bytes for a window shorter than one frame.
    idx = 0;
    accepted = 0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      took     = 1'b0;
      in_valid = (idx < 6);
      if (idx < 6) in_data = ovf[idx];
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        took = 1'b1;
      end
      if (fifo_count == 3'(DEPTH) && in_ready) bad++;
      @(negedge clk);
      if (took) begin
        idx++;
        accepted++;
      end
    end
    in_valid = 1'b0;
    check("ovf_accepted", accepted, 5);
    check("ovf_count_full", fifo_count, 4);
    check("ovf_ready_low", in_ready, 0);
    check("ovf_ready_while_full", bad, 0);
    wait_idle(6 * FRAME);
    check("ovf_drained", exp_q.size(), 0);

    // ena gating.
    ena = 1'b0;
    push_one(8'h3C, n);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("ena_tx_held_high", bad, 0);
    check("ena_count", fifo_count, 1);
    ena = 1'b1;
    @(negedge clk);
    check("ena_start_bit", tx, 0);
    check("ena_popped", fifo_count, 0);
    nf = frames_seen;
    repeat (10) @(negedge clk);
    ena = 1'b0;
    wait_idle(2 * FRAME);
    check("ena_frame_completed", frames_seen - nf, 1);
    ena = 1'b1;

    // Reset during DATA bit 3 with two bytes still queued.
    push_burst(8'hA1, 8'hB2, 8'hC3, n);
    wait_until(n + 1 + 4 * CPB + 1);
    check("midrst_queued", fifo_count, 2);
    check("midrst_in_data_bit3", tx, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_count", fifo_count, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    rst_n = 1'b1;
    nf  = frames_seen;
    bad = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("midrst_quiet", bad, 0);
    check("midrst_no_frames", frames_seen - nf, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
